// File: rtl/lock_pkg.sv
// Shared constants for the digital-lock controller and the display driver:
// gate status codes, digit-field geometry and the FSM state type.
package lock_pkg;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned FIELD_W  = DIGITS * NIBBLE_W;
  localparam int unsigned CNT_W    = 3;  // holds 0..DIGITS
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned STATUS_W = 3;

  localparam logic [STATUS_W-1:0] ST_OPEN    = 3'd1;
  localparam logic [STATUS_W-1:0] ST_IDLE    = 3'd2;
  localparam logic [STATUS_W-1:0] ST_ENTER   = 3'd3;
  localparam logic [STATUS_W-1:0] ST_CHANGE  = 3'd4;
  localparam logic [STATUS_W-1:0] ST_REENTER = 3'd5;
  localparam logic [STATUS_W-1:0] ST_SCROLL  = 3'd6;

  typedef enum logic [STATUS_W-1:0] {
    S_OPEN    = ST_OPEN,
    S_IDLE    = ST_IDLE,
    S_ENTER   = ST_ENTER,
    S_CHANGE  = ST_CHANGE,
    S_REENTER = ST_REENTER,
    S_SCROLL  = ST_SCROLL
  } lockState_e;

  function automatic logic isDigit(input logic [NIBBLE_W-1:0] code);
    return code < 4'd10;
  endfunction

endpackage

// File: rtl/lock_digit_buffer.sv
// Four-nibble entry field with fill count and last-written index.
// clr and wr may be raised together: the field is emptied and the digit lands in slot 0.
module lock_digit_buffer
  import lock_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr,
  input  logic [NIBBLE_W-1:0] digit,
  output logic [FIELD_W-1:0]  field,
  output logic [CNT_W-1:0]    count,
  output logic [IDX_W-1:0]    index
);

  logic [CNT_W-1:0] baseCnt;
  logic             doWr;

  assign baseCnt = clr ? '0 : count;
  assign doWr    = wr && (baseCnt < CNT_W'(DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field <= '0;
      count <= '0;
      index <= '0;
    end else begin
      if (clr) begin
        field <= '0;
        count <= '0;
        index <= '0;
      end
      // A write after a clear overrides only its own slot.
      if (doWr) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (baseCnt == CNT_W'(i))
            field[int'(FIELD_W) - int'(NIBBLE_W) * (i + 1) +: NIBBLE_W] <= digit;
        end
        index <= IDX_W'(baseCnt);
        count <= baseCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lock_ctrl_fsm.sv
// Digital-lock controller: password entry, change and lockout sequencing.
// Define LOCK_LOCKOUT_EN to build the fail counter and the SCROLL lockout state.
module lock_ctrl_fsm
  import lock_pkg::*;
#(
  parameter logic [FIELD_W-1:0] DEFAULT_PW    = 16'h1234,
  parameter int unsigned        MAX_FAILS     = 3,
  parameter int unsigned        ENTRY_TIMEOUT = 10_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic [NIBBLE_W-1:0] key_code,
  input  logic                btn_enter,
  input  logic                btn_change,
  input  logic                btn_lock,
  input  logic                finished_scrolling,
  output logic [FIELD_W-1:0]  display_elements,
  output logic [STATUS_W-1:0] gate_status,
  output logic [IDX_W-1:0]    current_index,
  output logic                unlocked
);

  localparam int unsigned   TO_W    = $clog2(ENTRY_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ENTRY_TIMEOUT - 1);

  lockState_e         state, nxtState;
  logic [FIELD_W-1:0] field, password, newPw;
  logic [CNT_W-1:0]   count;
  logic [TO_W-1:0]    toCnt;
  logic               keyDigit, full;
  logic               bufClr, bufWr, toClr, toInc, latchNew, commitPw;

`ifdef LOCK_LOCKOUT_EN
  localparam logic [2:0] FAIL_LIMIT = 3'(MAX_FAILS);
  logic [2:0] failCnt;
  logic       failInc, failClr;
`else
  localparam int unsigned unusedMaxFails = MAX_FAILS;
  logic unusedScroll;
  assign unusedScroll = finished_scrolling;
`endif

  assign keyDigit = key_valid && isDigit(key_code);
  assign full     = (count == CNT_W'(DIGITS));

  lock_digit_buffer u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bufClr),
    .wr    (bufWr),
    .digit (key_code),
    .field (field),
    .count (count),
    .index (current_index)
  );

  // Next-state and datapath strobes.
  always_comb begin
    nxtState = state;
    bufClr   = 1'b0;
    bufWr    = 1'b0;
    toClr    = 1'b0;
    toInc    = 1'b0;
    latchNew = 1'b0;
    commitPw = 1'b0;
`ifdef LOCK_LOCKOUT_EN
    failInc  = 1'b0;
    failClr  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (keyDigit) begin
          nxtState = S_ENTER;
          bufClr   = 1'b1;
          bufWr    = 1'b1;
          toClr    = 1'b1;
        end
      end
      S_OPEN: begin
        if (btn_lock) begin
          nxtState = S_IDLE;
        end else if (btn_change) begin
          nxtState = S_CHANGE;
          bufClr   = 1'b1;
          toClr    = 1'b1;
        end
      end
      S_ENTER, S_CHANGE, S_REENTER: begin
        // A key arriving with btn_enter is dropped; btn_enter sees the pre-key count.
        if (btn_enter && full) begin
          if (state == S_ENTER) begin
            if (field == password) begin
              nxtState = S_OPEN;
`ifdef LOCK_LOCKOUT_EN
              failClr  = 1'b1;
`endif
            end else begin
`ifdef LOCK_LOCKOUT_EN
              failInc  = 1'b1;
              nxtState = (failCnt + 3'd1 == FAIL_LIMIT) ? S_SCROLL : S_IDLE;
`else
              nxtState = S_IDLE;
`endif
            end
          end else if (state == S_CHANGE) begin
            latchNew = 1'b1;
            bufClr   = 1'b1;
            toClr    = 1'b1;
            nxtState = S_REENTER;
          end else begin
            commitPw = (field == newPw);
            nxtState = S_OPEN;
          end
        end else if (keyDigit && !btn_enter) begin
          bufWr = 1'b1;
          toClr = 1'b1;
        end else if (toCnt == TO_LAST) begin
          nxtState = (state == S_ENTER) ? S_IDLE : S_OPEN;
        end else begin
          toInc = 1'b1;
        end
      end
      S_SCROLL: begin
`ifdef LOCK_LOCKOUT_EN
        if (finished_scrolling) begin
          nxtState = S_IDLE;
          failClr  = 1'b1;
        end
`else
        nxtState = S_IDLE;
`endif
      end
      default: nxtState = S_IDLE;
    endcase
    if ((nxtState != state) && ((nxtState == S_IDLE) || (nxtState == S_OPEN)))
      bufClr = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      unlocked <= 1'b0;
      password <= DEFAULT_PW;
      newPw    <= '0;
      toCnt    <= '0;
    end else begin
      state    <= nxtState;
      unlocked <= (nxtState == S_OPEN);
      if (latchNew) newPw <= field;
      if (commitPw) password <= newPw;
      if (toClr)      toCnt <= '0;
      else if (toInc) toCnt <= toCnt + TO_W'(1);
    end
  end

`ifdef LOCK_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       failCnt <= '0;
    else if (failClr) failCnt <= '0;
    else if (failInc) failCnt <= failCnt + 3'd1;
  end
`endif

  assign gate_status      = state;
  assign display_elements = field;

endmodule
